// File: rtl/qei_vel_pkg.sv
// Shared types and default build constants for the qei velocity estimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qei_vel_pkg;

  // Position counter width from the qei block.
  localparam int QEI_RES    = 16;
  // Signed velocity output width.
  localparam int VEL_RES    = 12;
  // Clock cycles per velocity sample: 1 kHz at 48 MHz.
  localparam int VEL_PERIOD = 48000;

  // The first sample after reset/clear only records a reference position.
  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } primeState_e;

endpackage

// File: rtl/qei_vel_if.sv
// Bundles the control inputs and velocity result of one qei_vel instance.
// Latency: n/a (wiring only).
// Backpressure: none; the result is a one-cycle strobe the consumer must take.
interface qei_vel_if #(
  parameter int nbits = 16,
  parameter int vbits = 12
);
  logic                    en;
  logic                    clr;
  logic [nbits-1:0]        pos;
  logic signed [vbits-1:0] vel;
  logic                    valid;
  logic                    sat;

  modport master (output en, clr, pos, input vel, valid, sat);
  modport slave  (input en, clr, pos, output vel, valid, sat);
endinterface

// File: rtl/qei_vel_sat.sv
// Signed clamp of an inw-bit value into outw bits, with a flag when clamped.
// Latency: combinational.
// Backpressure: none.
module sat_s #(
  parameter int inw  = 18,
  parameter int outw = 12
) (
  input  logic signed [inw-1:0]  din,
  output logic signed [outw-1:0] dout,
  output logic                   clamped
);

  generate
    if (inw > outw) begin : gClamp
      localparam logic signed [inw-1:0] maxVal = {{(inw-outw+1){1'b0}}, {(outw-1){1'b1}}};
      localparam logic signed [inw-1:0] minVal = ~maxVal;

      // Pass in-range values through; pin anything outside to the nearest rail
      always_comb begin
        dout    = din[outw-1:0];
        clamped = 1'b0;
        if (din > maxVal) begin
          dout    = maxVal[outw-1:0];
          clamped = 1'b1;
        end else if (din < minVal) begin
          dout    = minVal[outw-1:0];
          clamped = 1'b1;
        end
      end
    end else begin : gPass
      // Output is at least as wide as the input: sign-extend, never clamps
      assign dout    = outw'(din);
      assign clamped = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/qei_vel.sv
// Per-wheel velocity: wrap-corrected position delta per period, saturated; QEI_VEL_AVG_EN adds a 4-sample mean.
// Latency: vel/sat/valid registered, visible one cycle after the sample edge.
// Backpressure: none; valid is a one-cycle strobe, vel and sat hold until the next sample.
module qei_vel
  import qei_vel_pkg::*;
#(
  parameter int nbits  = QEI_RES,
  parameter int vbits  = VEL_RES,
  parameter int period = VEL_PERIOD
) (
  input logic      clk,
  input logic      rst,
  qei_vel_if.slave bus
);

  localparam int            tw       = $clog2(period);
  localparam logic [tw-1:0] tickLast = tw'(period - 1);

  logic [tw-1:0]           tick;
  primeState_e             primeState, primeNext;
  logic [nbits-1:0]        prev;
  logic                    sampleEv;
  logic                    emitEv;
  logic signed [nbits-1:0] delta;
  logic signed [vbits-1:0] velNext, velQ;
  logic                    satNext, satQ, validQ;

  assign sampleEv = bus.en && (tick == tickLast);
  assign emitEv   = sampleEv && (primeState == PRIMED);
  // Modulo subtraction read as signed makes counter wrap transparent
  assign delta    = $signed(bus.pos - prev);

  // Sample-period counter: holds while en is low, wraps after the sample cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tick <= '0;
    else if (bus.clr)        tick <= '0;
    else if (bus.en)         tick <= (tick == tickLast) ? '0 : tick + 1'b1;
  end

  // Priming state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) primeState <= UNPRIMED;
    else      primeState <= primeNext;
  end

  // Priming next state: clear wins, any sample leaves us primed
  always_comb begin
    primeNext = primeState;
    if (bus.clr)       primeNext = UNPRIMED;
    else if (sampleEv) primeNext = PRIMED;
  end

  // Reference position for the next delta
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          prev <= '0;
    else if (bus.clr)  prev <= '0;
    else if (sampleEv) prev <= bus.pos;
  end

`ifdef QEI_VEL_AVG_EN
  localparam int sw = nbits + 2;

  // Three past deltas; the current delta is the fourth term of the mean
  logic signed [nbits-1:0] hist0, hist1, hist2;
  logic signed [sw-1:0]    sum, avg;

  assign sum = sw'(delta) + sw'(hist0) + sw'(hist1) + sw'(hist2);
  assign avg = sum >>> 2;

  // Delta history shifts only on emitted samples; zeros make the mean ramp in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (bus.clr) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
    end else if (emitEv) begin
      hist0 <= delta;
      hist1 <= hist0;
      hist2 <= hist1;
    end
  end

  sat_s #(.inw(sw), .outw(vbits)) uSat (
    .din     (avg),
    .dout    (velNext),
    .clamped (satNext)
  );
`else
  sat_s #(.inw(nbits), .outw(vbits)) uSat (
    .din     (delta),
    .dout    (velNext),
    .clamped (satNext)
  );
`endif

  // Result registers: valid pulses per emitted sample, vel/sat hold between
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      velQ   <= '0;
      satQ   <= 1'b0;
      validQ <= 1'b0;
    end else if (bus.clr) begin
      velQ   <= '0;
      satQ   <= 1'b0;
      validQ <= 1'b0;
    end else begin
      validQ <= emitEv;
      if (emitEv) begin
        velQ <= velNext;
        satQ <= satNext;
      end
    end
  end

  assign bus.vel   = velQ;
  assign bus.sat   = satQ;
  assign bus.valid = validQ;

endmodule

// File: tb/tb_qei_vel.sv
`timescale 1ns/1ps
// Bench for qei_vel: drives position/enable/clear, predicts each valid sample
// (value, clamp flag and the clock edge it must appear on) and checks it.
module tb_qei_vel;

  localparam int PER = 16;

  typedef struct {
    int vel;
    int sat;
    int edgeNo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  qei_vel_if #(.nbits(16), .vbits(12)) bus ();

  qei_vel #(.nbits(16), .vbits(12), .period(PER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  exp_t mon;
  int   checks;
  int   errs;
  int   edgeCnt;
  int   mtick;
  int   mprimed;
  int   mprev;
  int   mhist[3];
  int   posv;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare each valid strobe against the oldest prediction
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        mon = sbq.pop_front();
        chk("vel", int'(bus.vel), mon.vel);
        chk("sat", int'(bus.sat), mon.sat);
        chk("valid_edge", edgeCnt, mon.edgeNo);
      end
    end
  end

  task automatic modelClear();
    mtick   = 0;
    mprimed = 0;
    mprev   = 0;
    for (int i = 0; i < 3; i++) mhist[i] = 0;
  endtask

  // Drive one clock of stimulus and advance the reference model with it
  task automatic cyc(input bit e, input bit c, input int p);
    int   d;
    int   s;
    int   v;
    exp_t x;
    bus.en  = e;
    bus.clr = c;
    bus.pos = 16'(p);
    if (c) begin
      modelClear();
    end else if (e) begin
      if (mtick == PER - 1) begin
        mtick = 0;
        if (mprimed != 0) begin
          d = (p - mprev) & 32'hFFFF;
          if (d >= 32768) d -= 65536;
`ifdef QEI_VEL_AVG_EN
          s = (d + mhist[0] + mhist[1] + mhist[2]) >>> 2;
          mhist[2] = mhist[1];
          mhist[1] = mhist[0];
          mhist[0] = d;
`else
          s = d;
`endif
          v = (s > 2047) ? 2047 : ((s < -2048) ? -2048 : s);
          x.vel    = v;
          x.sat    = (v != s) ? 1 : 0;
          x.edgeNo = edgeCnt + 1;
          sbq.push_back(x);
        end
        mprimed = 1;
        mprev   = p & 32'hFFFF;
      end else begin
        mtick++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // n periods with en high, position stepping by dlt once per period
  task automatic runDelta(input int n, input int dlt);
    for (int k = 0; k < n; k++) begin
      repeat (PER) cyc(1'b1, 1'b0, posv);
      posv = (posv + dlt) & 32'hFFFF;
    end
  endtask

  task automatic runPos(input int p);
    posv = p;
    repeat (PER) cyc(1'b1, 1'b0, posv);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once
  task automatic doReset();
    rst = 1'b0;
    modelClear();
    sbq.delete();
    #2;
    chk("rst_vel", int'(bus.vel), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_sat", int'(bus.sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.en  = 1'b0;
    bus.clr = 1'b0;
    bus.pos = 16'd100;
    posv    = 100;
    rst     = 1'b0;
    doReset();

    // Fixed position: first sample primes, later ones report zero
    repeat (56) cyc(1'b1, 1'b0, 100);

    // Steady +5 per period
    runDelta(4, 5);

    // Counter wrap both ways
    runPos(65533);
    runPos(2);
    runPos(65533);

    // Saturation at both rails
    posv = 0;
    runDelta(3, 3000);
    runDelta(3, -3000);

    // Enable stall mid-period resumes from the held tick
    runDelta(2, 5);
    while (mtick != 5) cyc(1'b1, 1'b0, posv);
    repeat (40) cyc(1'b0, 1'b0, posv);
    runDelta(3, 5);

    // Clear at tick 7: outputs drop, next sample only primes
    while (mtick != 7) cyc(1'b1, 1'b0, posv);
    cyc(1'b1, 1'b1, posv);
    chk("clr_vel", int'(bus.vel), 0);
    chk("clr_valid", int'(bus.valid), 0);
    chk("clr_sat", int'(bus.sat), 0);
    runDelta(3, 5);

    // Asynchronous reset mid-period
    runDelta(1, 5);
    repeat (3) cyc(1'b1, 1'b0, posv);
    doReset();
    runDelta(3, 7);

    // Ramp-in from reset: +8 per period, then -1 per period
    doReset();
    posv = 0;
    runDelta(5, 8);
    doReset();
    posv = 0;
    runDelta(5, -1);

    repeat (4) cyc(1'b1, 1'b0, posv);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
